frs_message_queue_ctrl: RTL and testbench
=========================================

# frs_message_queue_ctrl

Controller for the PCIe Function Readiness Status (FRS) message queue in a Root Port. It accepts FRS messages decoded from the link and buffers them in a FIFO. It drives the FRS Message Received and FRS Message Overflow status bits and requests an MSI/MSI-X interrupt, using the vector selected by the FRS Queueing Capability register. It also supplies that register's queue max depth.

## Interface
- `QUEUE_DEPTH`, default 8: number of queue entries, 1..4095; need not be a power of two.
- `clk` in 1: clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `msg_valid` in 1: one received FRS message this cycle. There is no backpressure.
- `msg_func_id` in 16: requester Function ID.
- `msg_reason` in 4: FRS reason code.
- `frs_int_en` in 1: FRS interrupt enable (control register bit).
- `sts_wr` in 1: software write to the FRS status bits.
- `sts_wdata` in 2: RW1C data. bit0 = Received, bit1 = Overflow.
- `deq_wr` in 1: software write to the FRS Message Queue register; pops the head entry.
- `int_ack` in 1: MSI/MSI-X unit has sent the message.
- `queue_head` out 32: `{12'b0, reason, func_id}` of the head entry; 0 when empty.
- `queue_count` out 12: number of occupied entries.
- `queue_max_depth` out 12: constant `QUEUE_DEPTH`, for the capability register.
- `frs_msg_received` out 1: FRS Message Received status.
- `frs_msg_overflow` out 1: FRS Message Overflow status.
- `int_req` out 1: interrupt request; level, held until `int_ack`.

## Operation
- **Storage:** the queue is a circular buffer. It uses `rd_ptr`/`wr_ptr` of `$clog2(QUEUE_DEPTH)` bits plus a count. Each pointer wraps from `QUEUE_DEPTH-1` to 0 explicitly; power-of-two rollover must not be relied on.
- **Enqueue:** when `msg_valid` is high and the queue is not full, write the entry at `wr_ptr`, advance `wr_ptr`, increment count, and set Received.
- **Dequeue:** when `deq_wr` is high and the queue is not empty, advance `rd_ptr` and decrement count. `deq_wr` on an empty queue is ignored.
- **Enqueue and dequeue in the same cycle:**
  - Not empty: both happen and count is unchanged, including when the queue is full. Overflow is not set in that case.
  - Empty: only the enqueue happens.
- **Full, enqueue without dequeue:** the message is dropped and Overflow is set. See Configuration for the alternative.
- **Status bits:** Received and Overflow are RW1C through `sts_wr`/`sts_wdata`. A hardware set in the same cycle as a software clear leaves the bit set.
- **Interrupt FSM:**
  - States: IDLE, REQ.
  - Trigger: a rising edge of `frs_msg_received & frs_int_en`, taken against the registered previous value.
  - IDLE → REQ on the trigger.
  - REQ drives `int_req=1`. REQ → IDLE on `int_ack`.
  - A trigger that occurs while in REQ is not queued. A new edge is required after return to IDLE.
  - `frs_int_en` falling while in REQ does not withdraw the request.
- **Head output:** `queue_head` reads combinationally from the entry at `rd_ptr`, gated to 0 when count is 0.

## Timing
- **Reset values:** all state and outputs are 0, including pointers, count, both status bits, FSM = IDLE and `int_req`. `queue_max_depth` is always `QUEUE_DEPTH`.
- **Enqueue latency:** `msg_valid` at cycle N makes `queue_count`, `queue_head` (if the queue was empty) and `frs_msg_received` visible at N+1.
- **Interrupt latency:** `int_req` rises at N+2, provided `frs_int_en` was high at N+1.
- **Dequeue latency:** `deq_wr` at N gives the new head and count at N+1.
- **Acknowledge:** `int_ack` at N drops `int_req` at N+1.
- **Reset mid-operation:** synchronous reset discards all queued entries and any pending `int_req` on the next clock edge. No interrupt is generated for discarded entries.

## Configuration
- **`FRS_OVERWRITE_OLDEST_EN` defined:** an enqueue into a full queue without a dequeue discards the head entry. Both `rd_ptr` and `wr_ptr` advance, the new message is stored, count stays at `QUEUE_DEPTH`, and Overflow and Received are set.
- **Not defined:** the new message is dropped and the queue is unchanged, per Operation.

## Test plan
- **Reset then single message:** reset, then `msg_valid` with func_id=0x0100, reason=1.
  - Next cycle: `queue_head`=0x0001_0100, count=1, Received=1.
  - With `frs_int_en`=1: `int_req`=1 two cycles after `msg_valid`, and it drops the cycle after `int_ack`.
- **Fill and overflow (QUEUE_DEPTH=8):** enqueue func_ids 0..8.
  - Count=8 and Overflow=1.
  - Without the macro: the head is func_id 0.
  - With the macro: the head is func_id 1.
- **Full with simultaneous enqueue and dequeue:** count stays 8, Overflow stays 0, the head advances by one, and the new entry lands at the tail.
- **RW1C race:** `sts_wr` with `sts_wdata`=2'b01 in the same cycle as `msg_valid` leaves Received=1. `sts_wdata`=2'b11 with no event clears both bits.
- **Pointer wrap (QUEUE_DEPTH=5):** perform 12 enqueue/dequeue pairs. Every dequeue returns the data in order. `deq_wr` on empty leaves count at 0 and `queue_head` at 0.
- **Reset while `int_req` is high and 3 entries are queued:** the next cycle gives count=0, `int_req`=0 and both status bits 0.

Source files
------------

// File: rtl/frs_message_queue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : frs_message_queue_ctrl                                         |
// | Brief   : Root Port FRS message FIFO, RW1C status bits, MSI request FSM. |
// |           `FRS_OVERWRITE_OLDEST_EN: a full queue discards its oldest     |
// |           entry instead of the incoming message.                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module frs_message_queue_ctrl #(
  parameter int QUEUE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  input  logic [15:0] msg_func_id,
  input  logic [3:0]  msg_reason,
  input  logic        frs_int_en,
  input  logic        sts_wr,
  input  logic [1:0]  sts_wdata,
  input  logic        deq_wr,
  input  logic        int_ack,
  output logic [31:0] queue_head,
  output logic [11:0] queue_count,
  output logic [11:0] queue_max_depth,
  output logic        frs_msg_received,
  output logic        frs_msg_overflow,
  output logic        int_req
);

  localparam int              PTR_W      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [11:0]      c_DEPTH    = 12'(QUEUE_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  logic [19:0]      r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [11:0]      r_count;
  logic             r_received;
  logic             r_overflow;
  logic             r_trig_prev;
  logic             r_int_req;
  state_t           r_state;

  logic w_full;
  logic w_empty;
  logic w_do_enq;
  logic w_do_deq;
  logic w_full_drop;
  logic w_ovw;
  logic w_wr_en;
  logic w_rd_adv;
  logic w_trig;
  logic w_trig_edge;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_full      = (r_count == c_DEPTH);
  assign w_empty     = (r_count == 12'd0);
  assign w_do_deq    = deq_wr & ~w_empty;
  assign w_do_enq    = msg_valid & (~w_full | deq_wr);
  assign w_full_drop = msg_valid & w_full & ~deq_wr;
`ifdef FRS_OVERWRITE_OLDEST_EN
  assign w_ovw       = w_full_drop;
`else
  assign w_ovw       = 1'b0;
`endif
  assign w_wr_en     = w_do_enq | w_ovw;
  assign w_rd_adv    = w_do_deq | w_ovw;
  assign w_trig      = r_received & frs_int_en;
  assign w_trig_edge = w_trig & ~r_trig_prev;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {msg_reason, msg_func_id};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 12'd0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      if (w_do_enq && !w_do_deq) begin
        r_count <= r_count + 12'd1;
      end else if (w_do_deq && !w_do_enq) begin
        r_count <= r_count - 12'd1;
      end
    end
  end

  // Hardware set takes priority over a simultaneous RW1C clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_received <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_received <= w_wr_en     | (r_received & ~(sts_wr & sts_wdata[0]));
      r_overflow <= w_full_drop | (r_overflow & ~(sts_wr & sts_wdata[1]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_int_req   <= 1'b0;
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_prev <= w_trig;
      case (r_state)
        S_IDLE: begin
          if (w_trig_edge) begin
            r_state   <= S_REQ;
            r_int_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            r_state   <= S_IDLE;
            r_int_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_int_req <= 1'b0;
        end
      endcase
    end
  end

  assign queue_head       = w_empty ? 32'd0 : {12'd0, r_mem[r_rd_ptr]};
  assign queue_count      = r_count;
  assign queue_max_depth  = c_DEPTH;
  assign frs_msg_received = r_received;
  assign frs_msg_overflow = r_overflow;
  assign int_req          = r_int_req;

endmodule
`default_nettype wire

// File: tb/tb_frs_message_queue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_frs_message_queue_ctrl                                      |
// | Brief   : Directed self-checking bench, depth-8 and depth-5 instances.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_frs_message_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msg_valid, msg_valid5;
  logic [15:0] msg_func_id;
  logic [3:0]  msg_reason;
  logic        frs_int_en;
  logic        sts_wr;
  logic [1:0]  sts_wdata;
  logic        deq_wr, deq_wr5;
  logic        int_ack;

  logic [31:0] head8, head5;
  logic [11:0] count8, count5, maxd8, maxd5;
  logic        recv8, recv5, ovf8, ovf5, irq8, irq5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frs_message_queue_ctrl #(.QUEUE_DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_func_id(msg_func_id),
    .msg_reason(msg_reason), .frs_int_en(frs_int_en), .sts_wr(sts_wr),
    .sts_wdata(sts_wdata), .deq_wr(deq_wr), .int_ack(int_ack),
    .queue_head(head8), .queue_count(count8), .queue_max_depth(maxd8),
    .frs_msg_received(recv8), .frs_msg_overflow(ovf8), .int_req(irq8)
  );

  frs_message_queue_ctrl #(.QUEUE_DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid5), .msg_func_id(msg_func_id),
    .msg_reason(msg_reason), .frs_int_en(1'b0), .sts_wr(sts_wr),
    .sts_wdata(sts_wdata), .deq_wr(deq_wr5), .int_ack(int_ack),
    .queue_head(head5), .queue_count(count5), .queue_max_depth(maxd5),
    .frs_msg_received(recv5), .frs_msg_overflow(ovf5), .int_req(irq5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_head_fid;

  initial begin
    rst_n = 1'b0; msg_valid = 1'b0; msg_valid5 = 1'b0; msg_func_id = 16'h0;
    msg_reason = 4'h0; frs_int_en = 1'b0; sts_wr = 1'b0; sts_wdata = 2'b00;
    deq_wr = 1'b0; deq_wr5 = 1'b0; int_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    chk("rst_count", 32'(count8), 32'd0);
    chk("rst_head", head8, 32'd0);
    chk("rst_recv", 32'(recv8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    chk("rst_irq", 32'(irq8), 32'd0);
    chk("maxd8", 32'(maxd8), 32'd8);
    chk("maxd5", 32'(maxd5), 32'd5);

    // Single message with interrupt
    frs_int_en = 1'b1;
    msg_valid = 1'b1; msg_func_id = 16'h0100; msg_reason = 4'h1;
    tick();
    msg_valid = 1'b0;
    chk("single_head", head8, 32'h0001_0100);
    chk("single_count", 32'(count8), 32'd1);
    chk("single_recv", 32'(recv8), 32'd1);
    chk("irq_n1", 32'(irq8), 32'd0);
    tick();
    chk("irq_n2", 32'(irq8), 32'd1);
    tick();
    chk("irq_held", 32'(irq8), 32'd1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("irq_ack", 32'(irq8), 32'd0);
    tick();
    chk("irq_no_retrig", 32'(irq8), 32'd0);
    frs_int_en = 1'b0;

    sts_wr = 1'b1; sts_wdata = 2'b11;
    tick();
    sts_wr = 1'b0; sts_wdata = 2'b00;
    chk("clr_recv", 32'(recv8), 32'd0);
    deq_wr = 1'b1;
    tick();
    deq_wr = 1'b0;
    chk("deq_count", 32'(count8), 32'd0);
    chk("deq_head", head8, 32'd0);

    // Fill with func_ids 0..8; the ninth hits a full queue
    msg_reason = 4'h2;
    for (int i = 0; i < 9; i++) begin
      msg_valid = 1'b1; msg_func_id = 16'(i);
      tick();
      if (i == 7) begin
        chk("fill_ovf_pre", 32'(ovf8), 32'd0);
      end
    end
    msg_valid = 1'b0;
`ifdef FRS_OVERWRITE_OLDEST_EN
    exp_head_fid = 16'd1;
`else
    exp_head_fid = 16'd0;
`endif
    chk("full_count", 32'(count8), 32'd8);
    chk("full_ovf", 32'(ovf8), 32'd1);
    chk("full_head", head8, {12'd0, 4'h2, exp_head_fid});

    sts_wr = 1'b1; sts_wdata = 2'b11;
    tick();
    sts_wr = 1'b0; sts_wdata = 2'b00;
    chk("clr_ovf", 32'(ovf8), 32'd0);
    chk("clr_recv2", 32'(recv8), 32'd0);

    // Full queue, enqueue and dequeue together
    msg_valid = 1'b1; deq_wr = 1'b1; msg_func_id = 16'h00AA; msg_reason = 4'h3;
    tick();
    msg_valid = 1'b0; deq_wr = 1'b0;
    chk("fullrw_count", 32'(count8), 32'd8);
    chk("fullrw_ovf", 32'(ovf8), 32'd0);
    chk("fullrw_head", head8, {12'd0, 4'h2, exp_head_fid + 16'd1});
    for (int i = 0; i < 7; i++) begin
      deq_wr = 1'b1;
      tick();
    end
    deq_wr = 1'b0;
    chk("tail_head", head8, 32'h0003_00AA);
    chk("tail_count", 32'(count8), 32'd1);
    deq_wr = 1'b1;
    tick();
    deq_wr = 1'b0;
    chk("drain_count", 32'(count8), 32'd0);

    // RW1C race
    sts_wr = 1'b1; sts_wdata = 2'b11;
    tick();
    chk("race_pre", 32'(recv8), 32'd0);
    sts_wdata = 2'b01; msg_valid = 1'b1; msg_func_id = 16'h0077; msg_reason = 4'h5;
    tick();
    msg_valid = 1'b0;
    chk("race_recv", 32'(recv8), 32'd1);
    sts_wdata = 2'b11;
    tick();
    sts_wr = 1'b0; sts_wdata = 2'b00;
    chk("rw1c_recv", 32'(recv8), 32'd0);
    chk("rw1c_ovf", 32'(ovf8), 32'd0);
    chk("rw1c_count", 32'(count8), 32'd1);
    deq_wr = 1'b1;
    tick();
    deq_wr = 1'b0;

    // Pointer wrap on the depth-5 instance
    msg_reason = 4'h4;
    msg_valid5 = 1'b1; msg_func_id = 16'h5000;
    tick();
    chk("wrap_first", head5, 32'h0004_5000);
    for (int i = 1; i <= 12; i++) begin
      msg_valid5 = 1'b1; deq_wr5 = 1'b1; msg_func_id = 16'h5000 + 16'(i);
      tick();
      chk($sformatf("wrap_head_%0d", i), head5, {16'h0004, 16'h5000 + 16'(i)});
      chk($sformatf("wrap_cnt_%0d", i), 32'(count5), 32'd1);
    end
    msg_valid5 = 1'b0;
    tick();
    chk("wrap_last_deq", 32'(count5), 32'd0);
    tick();
    deq_wr5 = 1'b0;
    chk("empty_deq_count", 32'(count5), 32'd0);
    chk("empty_deq_head", head5, 32'd0);

    // Reset with a pending interrupt and three entries
    sts_wr = 1'b1; sts_wdata = 2'b11;
    tick();
    sts_wr = 1'b0; sts_wdata = 2'b00;
    frs_int_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      msg_valid = 1'b1; msg_func_id = 16'h0030 + 16'(i);
      tick();
    end
    msg_valid = 1'b0;
    chk("prerst_count", 32'(count8), 32'd3);
    chk("prerst_irq", 32'(irq8), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_count", 32'(count8), 32'd0);
    chk("midrst_irq", 32'(irq8), 32'd0);
    chk("midrst_recv", 32'(recv8), 32'd0);
    chk("midrst_ovf", 32'(ovf8), 32'd0);
    chk("midrst_head", head8, 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("postrst_irq", 32'(irq8), 32'd0);
    frs_int_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
